// File: rtl/bus_pkg.sv
// Shared constants and types for the CPU output-bus sink.
package bus_pkg;
    localparam int BUS_W = 8;
    localparam int BUS_DEPTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } hs_state_t;
endpackage

// File: rtl/bus_sink_if.sv
// CPU output bus: send strobe, data byte and received acknowledge.
interface bus_sink_if;
    import bus_pkg::*;

    logic             Bussent;
    logic [BUS_W-1:0] BusData;
    logic             Busreceived;

    modport master (
        output Bussent,
        output BusData,
        input  Busreceived
    );

    modport slave (
        input  Bussent,
        input  BusData,
        output Busreceived
    );
endinterface

// File: rtl/bus_sink_fifo.sv
// First-word-fall-through byte FIFO with count-derived full/empty flags.
module bus_sink_fifo
    import bus_pkg::*;
#(
    parameter int DEPTH = BUS_DEPTH,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [BUS_W-1:0] wr_data,
    input  logic             rd_en,
    output logic [BUS_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count
);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);
    assign push  = wr_en & ~full;
    assign pop   = rd_en & ~empty;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH because DEPTH == 2**AW.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/bus_sink.sv
// Bus-side endpoint: four-phase ack FSM, sticky error flags, FIFO buffer.
// Optional level interrupt enabled by defining BUS_SINK_IRQ_EN.
module bus_sink
    import bus_pkg::*;
#(
    parameter int DEPTH     = BUS_DEPTH,
    parameter int AW        = 2,
    parameter int IRQ_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    bus_sink_if.slave        bus,
    input  logic             rd_en,
    output logic [BUS_W-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             ovf_stall,
    output logic             udf,
    output logic             irq
);
    hs_state_t state;
    hs_state_t state_n;
    logic      wr;
    logic      ovf_set;

    bus_sink_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr),
        .wr_data (bus.BusData),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .empty   (empty),
        .full    (full),
        .count   (count)
    );

    // Ack is the ACK state itself, so reset drops it without a clock.
    assign bus.Busreceived = (state == ST_ACK);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        wr      = 1'b0;
        ovf_set = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.Bussent) begin
                    if (!full) begin
                        wr      = 1'b1;
                        state_n = ST_ACK;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
            end
            ST_ACK: begin
                if (!bus.Bussent) begin
                    state_n = ST_IDLE;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_stall <= 1'b0;
            udf       <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_stall <= 1'b1;
            end
            if (rd_en && empty) begin
                udf <= 1'b1;
            end
        end
    end

`ifdef BUS_SINK_IRQ_EN
    localparam logic [AW:0] IRQ_LVL = (AW+1)'(IRQ_LEVEL);

    logic        pop;
    logic [AW:0] cnt_n;

    assign pop = rd_en & ~empty;

    // Mirrors the FIFO count update so irq tracks count on the same edge.
    always_comb begin
        cnt_n = count;
        case ({wr, pop})
            2'b10:   cnt_n = count + 1'b1;
            2'b01:   cnt_n = count - 1'b1;
            default: cnt_n = count;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= (cnt_n >= IRQ_LVL);
        end
    end
`else
    localparam int unused_irq_level = IRQ_LEVEL;

    assign irq = 1'b0;
`endif
endmodule

// File: tb/tb_bus_sink.sv
// Directed self-checking bench for bus_sink: vector table plus corner sequences.
module tb_bus_sink;
    import bus_pkg::*;

    typedef struct {
        logic       s;
        logic [7:0] d;
        logic       r;
        logic       rcv;
        int         cnt;
        logic       full;
        logic       ovf;
        logic       chk;
        logic [7:0] q;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [2:0] count;
    logic       ovf_stall;
    logic       udf;
    logic       irq;

    int tests;
    int fails;
    vec_t vq[$];

    bus_sink_if bif ();

    bus_sink #(
        .DEPTH     (4),
        .AW        (2),
        .IRQ_LEVEL (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bif),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .count     (count),
        .ovf_stall (ovf_stall),
        .udf       (udf),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BUS_SINK_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic s, input logic [7:0] d, input logic r,
                       input logic rcv, input int cnt, input logic fl,
                       input logic ovf, input logic c, input logic [7:0] q);
        vec_t v;
        v.s = s; v.d = d; v.r = r; v.rcv = rcv; v.cnt = cnt;
        v.full = fl; v.ovf = ovf; v.chk = c; v.q = q;
        vq.push_back(v);
    endtask

    task automatic drive(input logic s, input logic [7:0] d, input logic r);
        bif.Bussent = s;
        bif.BusData = d;
        rd_en = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_rcv", bif.Busreceived, 0);
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_ovf", ovf_stall, 0);
        chk("rst_udf", udf, 0);
        chk("rst_irq", irq, 0);

        // single transfer
        add(1, 8'hA5, 0, 1, 1, 0, 0, 1, 8'hA5);
        add(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'hA5);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        // held request
        for (int i = 0; i < 5; i++) add(1, 8'h3C, 0, 1, 1, 0, 0, 1, 8'h3C);
        add(0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h3C);
        add(0, 8'h00, 1, 0, 0, 0, 0, 0, 8'h00);
        // fill to full
        for (int k = 1; k <= 4; k++) begin
            add(1, 8'(k), 0, 1, k, k == 4, 0, 1, 8'h01);
            add(0, 8'h00, 0, 0, k, k == 4, 0, 1, 8'h01);
        end
        add(1, 8'h05, 0, 0, 4, 1, 1, 1, 8'h01);
        add(1, 8'h05, 0, 0, 4, 1, 1, 1, 8'h01);
        add(1, 8'h05, 1, 0, 3, 0, 1, 1, 8'h02);
        add(1, 8'h05, 0, 1, 4, 1, 1, 1, 8'h02);
        add(0, 8'h00, 0, 0, 4, 1, 1, 1, 8'h02);
        add(0, 8'h00, 1, 0, 3, 0, 1, 1, 8'h03);
        add(0, 8'h00, 1, 0, 2, 0, 1, 1, 8'h04);
        add(0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h05);
        add(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00);
        // wrap and simultaneous read+write
        add(1, 8'h11, 0, 1, 1, 0, 1, 1, 8'h11);
        add(0, 8'h00, 0, 0, 1, 0, 1, 1, 8'h11);
        add(1, 8'h22, 0, 1, 2, 0, 1, 1, 8'h11);
        add(0, 8'h00, 0, 0, 2, 0, 1, 1, 8'h11);
        add(1, 8'h33, 1, 1, 2, 0, 1, 1, 8'h22);
        add(0, 8'h00, 1, 0, 1, 0, 1, 1, 8'h33);
        add(0, 8'h00, 1, 0, 0, 0, 1, 0, 8'h00);

        foreach (vq[i]) begin
            drive(vq[i].s, vq[i].d, vq[i].r);
            step();
            chk($sformatf("v%0d_rcv", i), bif.Busreceived, vq[i].rcv);
            chk($sformatf("v%0d_count", i), count, vq[i].cnt);
            chk($sformatf("v%0d_empty", i), empty, vq[i].cnt == 0);
            chk($sformatf("v%0d_full", i), full, vq[i].full);
            chk($sformatf("v%0d_ovf", i), ovf_stall, vq[i].ovf);
            chk($sformatf("v%0d_udf", i), udf, 0);
            chk($sformatf("v%0d_irq", i), irq, IRQ_ON && vq[i].cnt >= 2);
            if (vq[i].chk) chk($sformatf("v%0d_data", i), rd_data, vq[i].q);
        end

        // underflow
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("udf_flag", udf, 1);
        chk("udf_count", count, 0);
        chk("udf_empty", empty, 1);

        // reset mid-handshake
        drive(1'b1, 8'h44, 1'b0);
        step();
        chk("pre_rst_rcv", bif.Busreceived, 1);
        chk("pre_rst_count", count, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_rcv", bif.Busreceived, 0);
        chk("arst_count", count, 0);
        chk("arst_udf", udf, 0);
        chk("arst_ovf", ovf_stall, 0);
        chk("arst_empty", empty, 1);
        drive(1'b0, 8'h00, 1'b0);
        step();
        rst = 1'b0;
        #1;

        // irq level
        drive(1'b1, 8'h55, 1'b0);
        step();
        drive(1'b0, 8'h00, 1'b0);
        step();
        chk("irq_1byte", irq, 0);
        chk("irq_cnt1", count, 1);
        drive(1'b1, 8'h66, 1'b0);
        step();
        chk("irq_2byte", irq, IRQ_ON);
        drive(1'b0, 8'h00, 1'b0);
        step();
        chk("irq_hold", irq, IRQ_ON);
        drive(1'b0, 8'h00, 1'b1);
        step();
        chk("irq_pop", irq, 0);
        chk("irq_pop_cnt", count, 1);
        chk("irq_pop_data", rd_data, 8'h66);
        drive(1'b0, 8'h00, 1'b0);
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
